// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - two-port round-robin APB master with wait-state and timeout handling
module apb_master_arb #(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [AWIDTH-1:0] req0_addr,
    input  logic [DWIDTH-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [AWIDTH-1:0] req1_addr,
    input  logic [DWIDTH-1:0] req1_wdata,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]  state;
    logic        last_grant;
    logic        owner;
    logic [31:0] wait_cnt;
    logic        grant0, grant1;
    logic        hs0, hs1;
    logic        timed_out;
    logic        done;

    // On a tie the port opposite the last winner is granted.
    always_comb begin
        grant0    = req0_valid && (!req1_valid || last_grant);
        grant1    = req1_valid && (!req0_valid || !last_grant);
        req0_ready = (state == ST_IDLE) && grant0 && !PRESET;
        req1_ready = (state == ST_IDLE) && grant1 && !PRESET;
        hs0       = req0_valid && req0_ready;
        hs1       = req1_valid && req1_ready;
        // wait_cnt holds the number of earlier ACCESS cycles, so this fires on ACCESS cycle TIMEOUT.
        timed_out = (TIMEOUT != 0) && !PREADY && (wait_cnt == 32'(TIMEOUT - 1));
        done      = (state == ST_ACCESS) && (PREADY || timed_out);
        PSEL      = (state != ST_IDLE);
        PENABLE   = (state == ST_ACCESS);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            wait_cnt   <= '0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= done;
            case (state)
                ST_IDLE: begin
                    if (hs0 || hs1) begin
                        state      <= ST_SETUP;
                        PWRITE     <= hs0 ? req0_write : req1_write;
                        PADDR      <= hs0 ? req0_addr  : req1_addr;
                        PWDATA     <= hs0 ? req0_wdata : req1_wdata;
                        last_grant <= hs1;
                        owner      <= hs1;
                        wait_cnt   <= '0;
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (done) begin
                        state     <= ST_IDLE;
                        rsp_id    <= owner;
                        rsp_err   <= PREADY ? PSLVERR : 1'b1;
                        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
